// File: rtl/axis_arb_pkg.sv
// Shared state encodings, default widths and the round-robin pick used by the
// two-port packet arbiter.
package axis_arb_pkg;

  localparam int C_AXIS_TDATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF         = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Returns the port index to grant; the port that did not win last time has
  // priority when both are requesting.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register: holds a beat until the sink takes it
// and accepts a new beat in the same cycle the current one drains.
module axis_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_en,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [DATA_W/8-1:0] ld_strb,
  input  logic                ld_last,
  input  logic                rdy,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb,
  output logic                last,
  output logic                valid,
  output logic                free
);

  assign free = ~valid | rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      strb  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (ld_en) begin
      data  <= ld_data;
      strb  <= ld_strb;
      last  <= ld_last;
      valid <= 1'b1;
    end else if (rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Two-input AXI-Stream arbiter with packet-granular round-robin, a registered
// output stage and truncation of packets longer than the downstream buffer.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = C_AXIS_TDATA_WIDTH_DEF,
  parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,

  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tvalid,
  input  logic                            s00_axis_tlast,
  output logic                            s00_axis_tready,

  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                            s01_axis_tvalid,
  input  logic                            s01_axis_tlast,
  output logic                            s01_axis_tready,

  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  output logic                            m00_axis_tlast,
  input  logic                            m00_axis_tready,

  output logic                            arb_grant,
  output logic                            arb_busy,
  output logic                            pkt_trunc
);

  localparam int STRB_W = C_AXIS_TDATA_WIDTH / 8;
  // MAX_BEATS-1 is the all-ones count value.
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = '1;

  arb_state_t              state;
  logic                    grant;
  logic                    last_grant;
  logic [ADDR_WIDTH-1:0]   beat_cnt;
  logic                    busy;
  logic                    trunc;

  logic                    out_free;
  logic                    sel_valid;
  logic                    sel_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] sel_data;
  logic [STRB_W-1:0]       sel_strb;
  logic                    pass_ready;
  logic                    take;
  logic                    load;
  logic                    at_limit;
  logic                    fwd_last;

  always_comb begin
    sel_valid  = grant ? s01_axis_tvalid : s00_axis_tvalid;
    sel_last   = grant ? s01_axis_tlast  : s00_axis_tlast;
    sel_data   = grant ? s01_axis_tdata  : s00_axis_tdata;
    sel_strb   = grant ? s01_axis_tstrb  : s00_axis_tstrb;

    // XFER is throttled by the output register; DRAIN swallows freely.
    pass_ready = 1'b0;
    if (state == XFER) begin
      pass_ready = out_free;
    end else if (state == DRAIN) begin
      pass_ready = 1'b1;
    end

    s00_axis_tready = pass_ready & ~grant;
    s01_axis_tready = pass_ready &  grant;

    take     = sel_valid & pass_ready;
    load     = take & (state == XFER);
    at_limit = (beat_cnt == LAST_CNT);
    fwd_last = sel_last | at_limit;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      busy       <= 1'b0;
      trunc      <= 1'b0;
    end else begin
      trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (s00_axis_tvalid || s01_axis_tvalid) begin
            grant <= rr_pick(s00_axis_tvalid, s01_axis_tvalid, last_grant);
            state <= XFER;
            busy  <= 1'b1;
          end
        end
        XFER: begin
          if (take) begin
            if (sel_last) begin
              last_grant <= grant;
              beat_cnt   <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else if (at_limit) begin
              beat_cnt <= '0;
              trunc    <= 1'b1;
              state    <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (take && sel_last) begin
            last_grant <= grant;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign arb_grant = grant;
  assign arb_busy  = busy;
  assign pkt_trunc = trunc;

  axis_out_reg #(
    .DATA_W (C_AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .clk     (s00_axis_aclk),
    .rst_n   (s00_axis_aresetn),
    .ld_en   (load),
    .ld_data (sel_data),
    .ld_strb (sel_strb),
    .ld_last (fwd_last),
    .rdy     (m00_axis_tready),
    .data    (m00_axis_tdata),
    .strb    (m00_axis_tstrb),
    .last    (m00_axis_tlast),
    .valid   (m00_axis_tvalid),
    .free    (out_free)
  );

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter built with an 8-beat packet limit.
module tb_axis_pkt_arbiter;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic [3:0]    s0_strb, s1_strb, m_strb;
  logic          s0_valid, s0_last, s0_ready;
  logic          s1_valid, s1_last, s1_ready;
  logic          m_valid, m_last, m_ready;
  logic          grant, busy, trunc;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(
    .C_AXIS_TDATA_WIDTH (DW),
    .ADDR_WIDTH         (AW)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s0_data),
    .s00_axis_tstrb   (s0_strb),
    .s00_axis_tvalid  (s0_valid),
    .s00_axis_tlast   (s0_last),
    .s00_axis_tready  (s0_ready),
    .s01_axis_tdata   (s1_data),
    .s01_axis_tstrb   (s1_strb),
    .s01_axis_tvalid  (s1_valid),
    .s01_axis_tlast   (s1_last),
    .s01_axis_tready  (s1_ready),
    .m00_axis_tdata   (m_data),
    .m00_axis_tstrb   (m_strb),
    .m00_axis_tvalid  (m_valid),
    .m00_axis_tlast   (m_last),
    .m00_axis_tready  (m_ready),
    .arb_grant        (grant),
    .arb_busy         (busy),
    .pkt_trunc        (trunc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records accepted beats and checks stall stability.
  logic [31:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  int          cyc = 0;
  int          trunc_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_stall && rst_n) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
    end
    if (m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_cyc.push_back(cyc);
    end
    if (trunc) trunc_cnt++;
    prev_stall = m_valid && !m_ready && rst_n;
    prev_data  = m_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int port, input logic v, input logic [31:0] d, input logic l);
    if (port == 0) begin
      s0_valid = v; s0_data = d; s0_last = l; s0_strb = 4'hF;
    end else begin
      s1_valid = v; s1_data = d; s1_last = l; s1_strb = 4'hF;
    end
  endtask

  // Sends n beats base+1..base+n with tlast on the final one.
  task automatic send(input int port, input logic [31:0] base, input int n);
    int   waited;
    logic ok;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      ok = 1'b0;
      drive(port, 1'b1, base + 32'(i + 1), (i == n - 1));
      do begin
        @(negedge clk);
        ok = (port == 0) ? (s0_valid && s0_ready) : (s1_valid && s1_ready);
        @(posedge clk);
        #1;
        waited++;
      end while (!ok && waited < 300);
      if (!ok) check("hs_timeout", waited, 0);
    end
    drive(port, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] ed[$];
  logic        el[$];

  task automatic push_exp(input logic [31:0] d, input logic l);
    ed.push_back(d);
    el.push_back(l);
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, q_data.size(), ed.size());
    for (int i = 0; i < ed.size() && i < q_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q_data[i], ed[i]);
      check($sformatf("%s_last%0d", tag, i), q_last[i], el[i]);
    end
    q_data.delete(); q_last.delete(); q_cyc.delete();
    ed.delete(); el.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mvalid"}, m_valid, 0);
    check({tag, "_mlast"}, m_last, 0);
    check({tag, "_mdata"}, m_data, 0);
    check({tag, "_mstrb"}, m_strb, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_trunc"}, trunc, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_rdy0"}, s0_ready, 0);
    check({tag, "_rdy1"}, s1_ready, 0);
  endtask

  int   start_cyc;
  logic done33;
  int   guard;

  initial begin
    s0_valid = 0; s0_data = 0; s0_last = 0; s0_strb = 0;
    s1_valid = 0; s1_data = 0; s1_last = 0; s1_strb = 0;
    m_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_quiet("in_reset");
    rst_n = 1'b1;
    tick(3);
    check_quiet("post_reset");

    // Single 4-beat packet, 2-cycle input-to-output latency.
    start_cyc = cyc;
    send(0, 32'h0, 4);
    tick(4);
    if (q_cyc.size() == 4) begin
      check("lat_first", q_cyc[0] - start_cyc, 2);
      for (int i = 1; i < 4; i++) check($sformatf("lat_beat%0d", i), q_cyc[i] - q_cyc[0], i);
    end
    for (int i = 1; i <= 4; i++) push_exp(32'(i), (i == 4));
    compare_out("single");
    check("single_busy_after", busy, 0);

    // Fresh reset so port 0 wins the first contested grant.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    fork
      begin send(0, 32'hA0, 3); send(0, 32'hA3, 3); end
      begin send(1, 32'hB0, 3); send(1, 32'hB3, 3); end
    join
    tick(4);
    for (int i = 1; i <= 3; i++) push_exp(32'hA0 + 32'(i), (i == 3));
    for (int i = 1; i <= 3; i++) push_exp(32'hB0 + 32'(i), (i == 3));
    for (int i = 4; i <= 6; i++) push_exp(32'hA0 + 32'(i), (i == 6));
    for (int i = 4; i <= 6; i++) push_exp(32'hB0 + 32'(i), (i == 6));
    compare_out("rr");

    // Output backpressure toggling during a packet.
    fork
      send(0, 32'h50, 4);
      begin
        for (int i = 0; i < 14; i++) begin
          m_ready = (i % 2 == 0);
          @(negedge clk);
          if (busy) begin
            check("rdy_rule", s0_ready, (!m_valid || m_ready));
            check("rdy_other", s1_ready, 0);
          end
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    tick(4);
    for (int i = 1; i <= 4; i++) push_exp(32'h50 + 32'(i), (i == 4));
    compare_out("stall");

    // 10-beat packet cut at 8 beats, tail drained.
    trunc_cnt = 0;
    send(1, 32'h10, 10);
    tick(4);
    for (int i = 1; i <= 8; i++) push_exp(32'h10 + 32'(i), (i == 8));
    compare_out("trunc");
    check("trunc_pulses", trunc_cnt, 1);
    check("trunc_busy_after", busy, 0);

    fork
      send(0, 32'hC0, 1);
      send(1, 32'hD0, 1);
    join
    tick(4);
    push_exp(32'hC1, 1'b1);
    push_exp(32'hD1, 1'b1);
    compare_out("after_trunc");
    check("after_trunc_grant", grant, 1);

    // Reset mid-packet: beat 2 of 5 is aborted, remaining beats form a new packet.
    trunc_cnt = 0;
    done33 = 1'b0;
    fork
      begin send(0, 32'h60, 5); done33 = 1'b1; end
    join_none
    tick(3);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    tick(2);
    rst_n = 1'b1;
    guard = 0;
    while (!done33 && guard < 200) begin
      tick(1);
      guard++;
    end
    check("mid_reset_done", done33, 1);
    tick(4);
    push_exp(32'h61, 1'b0);
    for (int i = 3; i <= 5; i++) push_exp(32'h60 + 32'(i), (i == 5));
    compare_out("mid_reset");
    check("mid_reset_trunc", trunc_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
